// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  // One fetch bundle is two 32-bit slots; sequential fetch advances a whole bundle.
  localparam logic [31:0] FETCH_STEP = 32'd8;
  localparam logic [31:0] SLOT_STEP  = 32'd4;

  // Slot 0 sits in the upper half of the bundle at the bundle pc, slot 1 in the lower half at pc+4.
  localparam int SLOT0_HI = 63;
  localparam int SLOT0_LO = 32;
  localparam int SLOT1_HI = 31;
  localparam int SLOT1_LO = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] ir;
    logic        dual;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer between the icache response and decode.
// Push and pop may coincide (also when full); flush empties it in one cycle.
// While empty the head output keeps showing the last value it presented.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   r_mem [DEPTH];
  fetch_entry_t   r_last;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic           w_pop;

  assign o_valid = (r_count != '0);
  assign w_pop   = i_pop && o_valid;
  assign o_count = r_count;
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : r_last;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update; flush wins over push/pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  // Remember what was presented so the outputs hold once the buffer drains.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= '0;
    end else begin
      r_last <= o_head;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the icache pc, tracks the single
// outstanding request, handles redirect/replay/realign and feeds decode
// through fetch_fifo.
// Optional build macro FETCH_PERF_EN adds replay/realign/stall counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] pc,
  input  logic        icache_valid,
  input  logic [63:0] ir,
  input  logic        flag,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [63:0] out_ir,
  output logic        out_dual
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_replay,
  output logic [31:0] perf_realign,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_pc_q;
  logic          r_inflight;
  logic [CW-1:0] w_count;
  logic          w_credit;
  logic          w_issue;
  logic          w_resp;
  logic          w_replay;
  logic          w_realign;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  // Credit counts the response still in flight so a push can never overflow.
  assign w_credit  = ({1'b0, w_count} + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH);
  assign w_issue   = !redirect_valid && w_credit;
  // A redirect drops the response arriving in the same cycle.
  assign w_resp    = r_inflight && !redirect_valid;
  assign w_replay  = w_resp && !icache_valid;
  assign w_realign = w_resp && icache_valid && !flag;
  assign w_push    = w_resp && icache_valid;

  // Decode handshake: the head transfers on a cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and the
  // head stays stable until it transfers or a redirect flushes the buffer.
  assign w_pop     = out_valid && out_ready;

  assign w_entry   = '{pc: r_pc_q, ir: ir, dual: flag};
  assign pc        = r_pc;
  assign out_pc    = w_head.pc;
  assign out_ir    = w_head.ir;
  assign out_dual  = w_head.dual;

  // Pc / outstanding-request tracking; replay and realign squash the speculative issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= RESET_PC;
      r_pc_q     <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= align_pc(redirect_pc);
      r_inflight <= 1'b0;
    end else if (w_replay) begin
      r_pc       <= r_pc_q;
      r_inflight <= 1'b0;
    end else if (w_realign) begin
      r_pc       <= r_pc_q + SLOT_STEP;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc_q     <= r_pc;
      r_pc       <= r_pc + FETCH_STEP;
      r_inflight <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_valid (out_valid),
    .o_count (w_count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_replay;
  logic [31:0] r_perf_realign;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall      = !redirect_valid && !w_credit;
  assign perf_replay  = r_perf_replay;
  assign perf_realign = r_perf_realign;
  assign perf_stall   = r_perf_stall;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_replay  <= '0;
      r_perf_realign <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_replay  && (r_perf_replay  != 32'hFFFF_FFFF)) r_perf_replay  <= r_perf_replay  + 32'd1;
      if (w_realign && (r_perf_realign != 32'hFFFF_FFFF)) r_perf_realign <= r_perf_realign + 32'd1;
      if (w_stall   && (r_perf_stall   != 32'hFFFF_FFFF)) r_perf_stall   <= r_perf_stall   + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl. Icache model answers one cycle after each presented
// pc with data derived from the address. The scoreboard holds the program-order
// bundle stream implied by the response flags from the last fetch target.
module tb_fetch_ctrl;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc;
  logic        icache_valid;
  logic [63:0] ir;
  logic        flag;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [63:0] out_ir;
  logic        out_dual;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_replay;
  logic [31:0] perf_realign;
  logic [31:0] perf_stall;
`endif

  fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pc             (pc),
    .icache_valid   (icache_valid),
    .ir             (ir),
    .flag           (flag),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ir         (out_ir),
    .out_dual       (out_dual)
`ifdef FETCH_PERF_EN
    ,
    .perf_replay    (perf_replay),
    .perf_realign   (perf_realign),
    .perf_stall     (perf_stall)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int          n_tests;
  int          n_fail;
  int          n_pops;
  logic [96:0] exp_q[$];
  logic [31:0] m_addr;
  int          flag_mode;   // 0: every bundle dual, 1: only pc 8 single, 2: hashed
  int          valid_pct;
  logic [31:0] inval_addr;
  int          inval_left;

  function automatic logic flag_of(input logic [31:0] a);
    case (flag_mode)
      0:       return 1'b1;
      1:       return (a != 32'd8);
      default: return ((a[4:2] ^ a[7:5]) != 3'b000);
    endcase
  endfunction

  function automatic logic [63:0] ir_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  // Extend the expected program-order stream.
  task automatic fill();
    logic f;
    while (exp_q.size() < 16) begin
      f = flag_of(m_addr);
      exp_q.push_back({m_addr, ir_of(m_addr), f});
      m_addr = m_addr + (f ? 32'd8 : 32'd4);
    end
  endtask

  task automatic restart(input logic [31:0] target);
    exp_q.delete();
    m_addr = {target[31:2], 2'b00};
    fill();
  endtask

  // One clock: score a pop about to happen, then answer the icache request.
  task automatic tick();
    logic [31:0] a;
    logic [96:0] e;
    logic [96:0] got;
    a = pc;
    if (rstn && out_valid && out_ready) begin
      n_pops++;
      fill();
      e = exp_q.pop_front();
      got = {out_pc, out_ir, out_dual};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pop_stream: got pc=%h ir=%h dual=%b, expected pc=%h ir=%h dual=%b",
                 got[96:65], got[64:1], got[0], e[96:65], e[64:1], e[0]);
      end
    end
    if (rstn && redirect_valid) restart(redirect_pc);
    @(posedge clk);
    #1;
    if (inval_left > 0 && a == inval_addr) begin
      icache_valid = 1'b0;
      inval_left--;
    end else begin
      icache_valid = ($urandom_range(99) < valid_pct);
    end
    ir   = ir_of(a);
    flag = flag_of(a);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    redirect_valid = 1'b0;
    icache_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    restart(RESET_PC);
    rstn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    flag_mode = 0; valid_pct = 100; out_ready = 1'b1;
    rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_tests++;
    if (pc !== RESET_PC || out_valid !== 1'b0 || out_pc !== 32'd0 || out_ir !== 64'd0 || out_dual !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h out_valid=%b out_pc=%h out_ir=%h out_dual=%b, expected all zero",
               pc, out_valid, out_pc, out_ir, out_dual);
    end
    restart(RESET_PC);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    // asynchronous reset in the middle of a cycle
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_tests++;
    if (pc !== RESET_PC || out_valid !== 1'b0 || out_pc !== 32'd0 || out_ir !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h out_valid=%b out_pc=%h out_ir=%h, expected pc=%h and empty zeroed outputs",
               pc, out_valid, out_pc, out_ir, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    flag_mode = 0; valid_pct = 100; out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (pc !== 32'(8 * k)) begin
        n_fail++;
        $display("FAIL seq_pc: cycle %0d pc=%h, expected %h", k, pc, 32'(8 * k));
      end
      n_tests++;
      if (k < 2) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL seq_latency: cycle %0d out_valid=%b, expected 0", k, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_pc !== 32'(8 * (k - 2)) || out_dual !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_out: cycle %0d out_valid=%b out_pc=%h out_dual=%b, expected 1 %h 1",
                 k, out_valid, out_pc, out_dual, 32'(8 * (k - 2)));
      end
      tick();
    end
  endtask

  task automatic test_realign();
    logic [31:0] trace [7];
    trace = '{32'd0, 32'd8, 32'd16, 32'd12, 32'd20, 32'd28, 32'd36};
    flag_mode = 1; valid_pct = 100; out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (pc !== trace[k]) begin
        n_fail++;
        $display("FAIL realign_pc: cycle %0d pc=%h, expected %h", k, pc, trace[k]);
      end
      if (k == 3) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'd8 || out_dual !== 1'b0) begin
          n_fail++;
          $display("FAIL realign_entry: out_valid=%b out_pc=%h out_dual=%b, expected 1 8 0", out_valid, out_pc, out_dual);
        end
      end
      if (k == 4) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL realign_bubble: out_valid=%b, expected 0", out_valid);
        end
      end
      if (k == 5) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'd12) begin
          n_fail++;
          $display("FAIL realign_next: out_valid=%b out_pc=%h, expected 1 c", out_valid, out_pc);
        end
      end
      tick();
    end
    for (int k = 0; k < 6; k++) tick();
`ifdef FETCH_PERF_EN
    n_tests++;
    if (perf_realign !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_realign: got %0d, expected 1", perf_realign);
    end
`endif
  endtask

  task automatic test_replay();
    logic [31:0] trace [12];
    trace = '{32'd0, 32'd8, 32'd16, 32'd24, 32'd16, 32'd24, 32'd16, 32'd24, 32'd16, 32'd24, 32'd32, 32'd40};
    flag_mode = 0; valid_pct = 100; out_ready = 1'b1;
    inval_addr = 32'd16; inval_left = 3;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (pc !== trace[k]) begin
        n_fail++;
        $display("FAIL replay_pc: cycle %0d pc=%h, expected %h", k, pc, trace[k]);
      end
      tick();
    end
    inval_left = 0;
    for (int k = 0; k < 6; k++) tick();
`ifdef FETCH_PERF_EN
    n_tests++;
    if (perf_replay !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_replay: got %0d, expected 3", perf_replay);
    end
`endif
  endtask

  task automatic test_stall();
    int p0;
    flag_mode = 0; valid_pct = 100; out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (pc !== ((k < 4) ? 32'(8 * k) : 32'd32) || out_valid !== (k >= 2)) begin
        n_fail++;
        $display("FAIL stall_pc: cycle %0d pc=%h out_valid=%b, expected %h %b",
                 k, pc, out_valid, (k < 4) ? 32'(8 * k) : 32'd32, (k >= 2));
      end
      tick();
    end
    out_ready = 1'b1;
    p0 = n_pops;
    for (int k = 0; k < 24; k++) tick();
    n_tests++;
    if (n_pops - p0 < 20) begin
      n_fail++;
      $display("FAIL stall_drain: %0d bundles delivered in 24 cycles, expected at least 20", n_pops - p0);
    end
`ifdef FETCH_PERF_EN
    n_tests++;
    if (perf_stall !== 32'd6) begin
      n_fail++;
      $display("FAIL perf_stall: got %0d, expected 6", perf_stall);
    end
`endif
  endtask

  task automatic test_redirect();
    flag_mode = 0; valid_pct = 100; out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    n_tests++;
    if (out_valid !== 1'b1 || pc !== 32'd32) begin
      n_fail++;
      $display("FAIL redirect_pre: out_valid=%b pc=%h, expected 1 20", out_valid, pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1000;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || pc !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL redirect_flush: out_valid=%b pc=%h, expected 0 1000", out_valid, pc);
    end
    out_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL redirect_first: out_valid=%b out_pc=%h, expected 1 1000", out_valid, out_pc);
    end
    for (int k = 0; k < 10; k++) tick();
  endtask

  task automatic test_wrap();
    flag_mode = 0; valid_pct = 100; out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFB;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (pc !== 32'hFFFF_FFF8 + 32'(8 * k)) begin
        n_fail++;
        $display("FAIL wrap_pc: step %0d pc=%h, expected %h", k, pc, 32'hFFFF_FFF8 + 32'(8 * k));
      end
      tick();
    end
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_random();
    int p0;
    flag_mode = 2; valid_pct = 70; out_ready = 1'b1;
    do_reset();
    p0 = n_pops;
    for (int k = 0; k < 600; k++) begin
      out_ready = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(39) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    n_tests++;
    if (n_pops - p0 < 100) begin
      n_fail++;
      $display("FAIL random_progress: %0d bundles delivered in 600 cycles, expected at least 100", n_pops - p0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0; n_fail = 0; n_pops = 0;
    rstn = 1'b0; icache_valid = 1'b0; ir = '0; flag = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    flag_mode = 0; valid_pct = 100; inval_addr = '0; inval_left = 0;
    m_addr = RESET_PC;
    test_reset();
    test_sequential();
    test_realign();
    test_replay();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
